breg_param: RTL and testbench

Parametrised multi-port register file and the next generation of the team's 4x8 register bank. It has configurable data width and depth, two read ports and two write ports with defined collision priority, optional write-to-read bypass, and an optional hardwired-zero entry 0. A sequential clear engine zeroes the array one entry per cycle without asserting reset. It sits beside datapath ALUs as operand storage.

---
 rtl/breg_pkg.sv | 24 ++
 rtl/breg_clr_fsm.sv | 66 ++++++
 rtl/breg_param.sv | 107 ++++++++++
 tb/tb_breg_param.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/breg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : breg_pkg
//  Description : Shared types and helpers for the breg_param register file.
//                Holds the clear-engine state encoding and the address-width
//                helper used by the top and the clear FSM.
//  Revision    : 1.0 - initial release
// ============================================================================
package breg_pkg;

    // Clear-engine states; 1-bit encoding, idle is the reset value.
    typedef enum logic [0:0] {
        CLR_IDLE  = 1'b0,
        CLR_SWEEP = 1'b1
    } clr_state_t;

    // Address width for a given depth. The result is never below 1, so a
    // 2-entry file still gets a real address bit.
    function automatic int addr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage : breg_pkg
`default_nettype wire

// File: rtl/breg_clr_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : breg_clr_fsm
//  Description : Sequential clear engine. On i_start while idle it walks a
//                pointer from 0 to DEPTH-1, requesting one entry clear per
//                cycle, then drops back to idle.
//  Ports       : clk, rst (async, active-high)
//                i_start    - sweep request, sampled only while idle
//                o_busy     - sweep in progress
//                o_clr_en   - clear o_clr_addr on this rising edge
//                o_clr_addr - entry being cleared this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module breg_clr_fsm
    import breg_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_clr_en,
    output logic [ADDR_W-1:0] o_clr_addr
);

    localparam logic [ADDR_W-1:0] c_last = ADDR_W'(DEPTH - 1);

    clr_state_t        r_state;
    logic [ADDR_W-1:0] r_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= CLR_IDLE;
            r_ptr   <= '0;
        end else begin
            case (r_state)
                CLR_IDLE: begin
                    if (i_start) begin
                        r_state <= CLR_SWEEP;
                        r_ptr   <= '0;
                    end
                end
                CLR_SWEEP: begin
                    // Pointer wraps to 0 naturally as the last entry clears.
                    r_ptr <= r_ptr + ADDR_W'(1);
                    if (r_ptr == c_last) begin
                        r_state <= CLR_IDLE;
                    end
                end
                default: begin
                    r_state <= CLR_IDLE;
                    r_ptr   <= '0;
                end
            endcase
        end
    end

    // Decoded straight from the state flop so reset drops busy immediately.
    assign o_busy     = (r_state == CLR_SWEEP);
    assign o_clr_en   = (r_state == CLR_SWEEP);
    assign o_clr_addr = r_ptr;

endmodule : breg_clr_fsm
`default_nettype wire

// File: rtl/breg_param.sv
`default_nettype none
// ============================================================================
//  Module      : breg_param
//  Description : Parametrised 2-read / 2-write register file with port-1
//                write priority, optional write-to-read bypass, optional
//                hardwired-zero entry 0 and a sequential sweep clear.
//  Ports       : clk, rst (async, active-high)
//                wr0_en/addr/data, wr1_en/addr/data - write ports
//                rd0_addr/data, rd1_addr/data       - combinational reads
//                clr_start  - start a sweep clear (idle only)
//                clr_busy   - sweep running, writes dropped
//                wr_conflict- one-cycle pulse after a same-entry collision
//  Revision    : 1.0 - initial release
// ============================================================================
module breg_param
    import breg_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 4,
    parameter bit ZERO_REG = 1'b0,
    parameter bit BYPASS   = 1'b1,
    localparam int ADDR_W  = addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr0_en,
    input  logic [ADDR_W-1:0] wr0_addr,
    input  logic [DATA_W-1:0] wr0_data,
    input  logic              wr1_en,
    input  logic [ADDR_W-1:0] wr1_addr,
    input  logic [DATA_W-1:0] wr1_data,
    input  logic [ADDR_W-1:0] rd0_addr,
    output logic [DATA_W-1:0] rd0_data,
    input  logic [ADDR_W-1:0] rd1_addr,
    output logic [DATA_W-1:0] rd1_data,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              wr_conflict
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              r_wr_conflict;

    logic              w_busy;
    logic              w_clr_en;
    logic [ADDR_W-1:0] w_clr_addr;
    logic              w_wr0_ok;
    logic              w_wr1_ok;

    breg_clr_fsm #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clr_fsm (
        .clk        (clk),
        .rst        (rst),
        .i_start    (clr_start),
        .o_busy     (w_busy),
        .o_clr_en   (w_clr_en),
        .o_clr_addr (w_clr_addr)
    );

    // A write is "accepted" only when it will really land in the array.
    // Excluding the zero entry here keeps it out of bypass and of the
    // conflict flag in one place.
    assign w_wr0_ok = wr0_en && !w_busy && !(ZERO_REG && (wr0_addr == '0));
    assign w_wr1_ok = wr1_en && !w_busy && !(ZERO_REG && (wr1_addr == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_conflict <= 1'b0;
        end else begin
            if (w_clr_en) begin
                r_mem[w_clr_addr] <= '0;
            end
            // Port 1 is written last so it wins a same-address collision.
            if (w_wr0_ok) begin
                r_mem[wr0_addr] <= wr0_data;
            end
            if (w_wr1_ok) begin
                r_mem[wr1_addr] <= wr1_data;
            end
            r_wr_conflict <= w_wr0_ok && w_wr1_ok && (wr0_addr == wr1_addr);
        end
    end

    always_comb begin
        rd0_data = r_mem[rd0_addr];
        rd1_data = r_mem[rd1_addr];
        if (BYPASS) begin
            // Port 1 checked last to give it bypass priority.
            if (w_wr0_ok && (wr0_addr == rd0_addr)) rd0_data = wr0_data;
            if (w_wr1_ok && (wr1_addr == rd0_addr)) rd0_data = wr1_data;
            if (w_wr0_ok && (wr0_addr == rd1_addr)) rd1_data = wr0_data;
            if (w_wr1_ok && (wr1_addr == rd1_addr)) rd1_data = wr1_data;
        end
        if (ZERO_REG && (rd0_addr == '0)) rd0_data = '0;
        if (ZERO_REG && (rd1_addr == '0)) rd1_data = '0;
    end

    assign clr_busy    = w_busy;
    assign wr_conflict = r_wr_conflict;

endmodule : breg_param
`default_nettype wire

// File: tb/tb_breg_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_breg_param
//  Description : Scoreboard bench for breg_param. Instance A uses the
//                defaults (ZERO_REG=0, BYPASS=1); instance B uses ZERO_REG=1,
//                BYPASS=0. Both share every input. Stimulus pushes expected
//                values tagged with a cycle number; a monitor on the falling
//                edge pops and compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_breg_param;

    localparam int DW = 8;
    localparam int AW = 2;

    // Output selectors for the scoreboard.
    localparam int S_RD0_A = 0, S_RD1_A = 1, S_BUSY_A = 2, S_CONF_A = 3;
    localparam int S_RD0_B = 4, S_RD1_B = 5, S_BUSY_B = 6, S_CONF_B = 7;

    typedef struct {
        int          cyc;
        int          sig;
        logic [7:0]  val;
        int          tag;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr0_en, wr1_en, clr_start;
    logic [AW-1:0] wr0_addr, wr1_addr, rd0_addr, rd1_addr;
    logic [DW-1:0] wr0_data, wr1_data;
    logic [DW-1:0] rd0_a, rd1_a, rd0_b, rd1_b;
    logic          busy_a, busy_b, conf_a, conf_b;

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    bit   done = 1'b0;
    exp_t q[$];

    breg_param #(.DATA_W(DW), .DEPTH(4), .ZERO_REG(1'b0), .BYPASS(1'b1)) dut_a (
        .clk(clk), .rst(rst),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .rd0_addr(rd0_addr), .rd0_data(rd0_a),
        .rd1_addr(rd1_addr), .rd1_data(rd1_a),
        .clr_start(clr_start), .clr_busy(busy_a), .wr_conflict(conf_a)
    );

    breg_param #(.DATA_W(DW), .DEPTH(4), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_b (
        .clk(clk), .rst(rst),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .rd0_addr(rd0_addr), .rd0_data(rd0_b),
        .rd1_addr(rd1_addr), .rd1_data(rd1_b),
        .clr_start(clr_start), .clr_busy(busy_b), .wr_conflict(conf_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] actual(input int sig);
        case (sig)
            S_RD0_A:  return rd0_a;
            S_RD1_A:  return rd1_a;
            S_BUSY_A: return {7'd0, busy_a};
            S_CONF_A: return {7'd0, conf_a};
            S_RD0_B:  return rd0_b;
            S_RD1_B:  return rd1_b;
            S_BUSY_B: return {7'd0, busy_b};
            default:  return {7'd0, conf_b};
        endcase
    endfunction

    // Monitor: compare every expectation due in the current cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            logic [7:0] a;
            e = q.pop_front();
            a = actual(e.sig);
            n_tests++;
            if (e.cyc != cyc) begin
                n_fail++;
                $display("FAIL chk%0d sig%0d: stale expectation cycle %0d at cycle %0d",
                         e.tag, e.sig, e.cyc, cyc);
            end else if (a !== e.val) begin
                n_fail++;
                $display("FAIL chk%0d sig%0d cyc%0d: got 0x%02h expected 0x%02h",
                         e.tag, e.sig, cyc, a, e.val);
            end
        end
    end

    int tag = 0;
    task automatic expect_v(input int sig, input logic [7:0] val);
        exp_t e;
        e.cyc = cyc; e.sig = sig; e.val = val; e.tag = tag;
        tag++;
        q.push_back(e);
    endtask

    // Advance to just after the next rising edge with all strobes cleared.
    task automatic step();
        @(posedge clk);
        #1;
        wr0_en = 1'b0; wr1_en = 1'b0; clr_start = 1'b0;
    endtask

    task automatic wr0(input logic [AW-1:0] a, input logic [7:0] d);
        wr0_en = 1'b1; wr0_addr = a; wr0_data = d;
    endtask

    task automatic wr1(input logic [AW-1:0] a, input logic [7:0] d);
        wr1_en = 1'b1; wr1_addr = a; wr1_data = d;
    endtask

    task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd0_addr = a0; rd1_addr = a1;
    endtask

    task automatic busy_both(input logic b);
        expect_v(S_BUSY_A, {7'd0, b});
        expect_v(S_BUSY_B, {7'd0, b});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        wr0_en = 0; wr1_en = 0; clr_start = 0;
        wr0_addr = 0; wr1_addr = 0; wr0_data = 0; wr1_data = 0;
        rd0_addr = 0; rd1_addr = 0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // 1. Reset state on every address, both ports.
        for (int i = 0; i < 4; i++) begin
            step();
            rd(AW'(i), AW'(3 - i));
            expect_v(S_RD0_A, 8'h00); expect_v(S_RD1_A, 8'h00);
            expect_v(S_RD0_B, 8'h00); expect_v(S_RD1_B, 8'h00);
            busy_both(1'b0);
            expect_v(S_CONF_A, 8'h00); expect_v(S_CONF_B, 8'h00);
        end

        // 2. Write path and bypass.
        step(); wr0(2, 8'hA5); rd(2, 0);
        expect_v(S_RD0_A, 8'hA5);           // bypass
        expect_v(S_RD0_B, 8'h00);           // pre-edge value
        step(); wr1(2, 8'h3C); rd(2, 2);
        expect_v(S_RD1_A, 8'h3C);
        expect_v(S_RD1_B, 8'hA5);
        expect_v(S_RD0_A, 8'h3C);
        expect_v(S_RD0_B, 8'hA5);
        step(); rd(2, 2);
        expect_v(S_RD0_A, 8'h3C); expect_v(S_RD1_B, 8'h3C);
        expect_v(S_CONF_A, 8'h00);

        // 3. Same-cycle collision on r1: port 1 wins, one-cycle flag.
        step(); wr0(1, 8'h11); wr1(1, 8'h22); rd(1, 1);
        expect_v(S_RD0_A, 8'h22);
        expect_v(S_RD0_B, 8'h00);
        expect_v(S_CONF_A, 8'h00);
        step(); rd(1, 1);
        expect_v(S_RD0_A, 8'h22); expect_v(S_RD1_B, 8'h22);
        expect_v(S_CONF_A, 8'h01); expect_v(S_CONF_B, 8'h01);
        step();
        expect_v(S_CONF_A, 8'h00); expect_v(S_CONF_B, 8'h00);

        // 4. Entry 0 writes: real entry in A, hardwired zero in B.
        step(); wr0(0, 8'hFF); wr1(0, 8'hFF); rd(0, 0);
        expect_v(S_RD0_A, 8'hFF); expect_v(S_RD0_B, 8'h00);
        step(); rd(0, 0);
        expect_v(S_RD0_A, 8'hFF); expect_v(S_RD0_B, 8'h00);
        expect_v(S_RD1_B, 8'h00);
        expect_v(S_CONF_A, 8'h01); expect_v(S_CONF_B, 8'h00);
        step();
        expect_v(S_CONF_A, 8'h00); expect_v(S_CONF_B, 8'h00);

        // 5. Sweep clear.
        step(); wr0(0, 8'h01); wr1(1, 8'h02);
        step(); wr0(2, 8'h03); wr1(3, 8'h04);
        step(); clr_start = 1'b1; wr0(2, 8'h55); rd(3, 2);   // idle: write commits
        busy_both(1'b0);
        expect_v(S_RD0_A, 8'h04); expect_v(S_RD0_B, 8'h04);
        expect_v(S_RD1_A, 8'h55); expect_v(S_RD1_B, 8'h03);
        step(); rd(3, 2);                                   // busy 1, clears r0
        busy_both(1'b1);
        expect_v(S_RD1_A, 8'h55); expect_v(S_RD1_B, 8'h55);
        step(); wr0(3, 8'h77); rd(3, 0);                    // busy 2, write dropped
        busy_both(1'b1);
        expect_v(S_RD0_A, 8'h04);                           // no bypass while busy
        expect_v(S_RD1_A, 8'h00);                           // r0 already cleared
        step(); clr_start = 1'b1; rd(3, 2);                 // busy 3, start ignored
        busy_both(1'b1);
        expect_v(S_RD0_A, 8'h04);
        expect_v(S_RD1_A, 8'h55);                           // being cleared, old data
        step(); rd(3, 1);                                   // busy 4
        busy_both(1'b1);
        expect_v(S_RD0_A, 8'h04); expect_v(S_RD0_B, 8'h04);
        for (int i = 0; i < 2; i++) begin
            step(); rd(AW'(2 * i), AW'(2 * i + 1));
            busy_both(1'b0);
            expect_v(S_RD0_A, 8'h00); expect_v(S_RD1_A, 8'h00);
            expect_v(S_RD0_B, 8'h00); expect_v(S_RD1_B, 8'h00);
        end

        // 6. Reset in the middle of a sweep.
        step(); wr0(3, 8'h09);
        step(); clr_start = 1'b1; rd(3, 3);
        expect_v(S_RD0_A, 8'h09);
        step();
        busy_both(1'b1);
        step(); #1 rst = 1'b1;                              // busy 2, async reset
        #1;
        busy_both(1'b0);
        expect_v(S_RD0_A, 8'h00); expect_v(S_RD1_B, 8'h00);
        step(); rst = 1'b0;
        busy_both(1'b0);
        step(); clr_start = 1'b1;
        busy_both(1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            busy_both(1'b1);
        end
        step();
        busy_both(1'b0);

        step(); step();
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
        end
        done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_breg_param
`default_nettype wire
